sound_noise_channel_gen: RTL and testbench

- Parametrised next-generation noise (channel-4 style) generator for the sound subsystem.
- Takes decoded register fields and frame-sequencer strobes directly; the IO bus parser sits outside.
- Provides an LFSR of configurable width with a short-mode tap, a programmable divisor/shift clock, a length counter, a volume envelope and DAC gating.
- Produces an unsigned sample plus a channel-on flag for the mixer.

---
 rtl/sound_noise_channel_gen.sv | 193 +++++++++++++++++++
 tb/tb_sound_noise_channel_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_noise_channel_gen.sv
// Noise channel generator: LFSR noise source with programmable shift clock,
// length counter, volume envelope and DAC gating, feeding the sound mixer.
//
// Ports:
//   I_CLK       system clock
//   I_RESET     asynchronous active-high reset
//   I_CLK_EN    frequency-timer enable (4.194304 MHz equivalent)
//   I_TICK_256  length-counter strobe (one cycle)
//   I_TICK_64   envelope strobe (one cycle)
//   I_LEN_WE    load length counter from I_LEN
//   I_LEN       length field L
//   I_ENV       {initial volume, direction (1 = up), period[2:0]}
//   I_POLY      {s[3:0], width_short, r[2:0]}
//   I_LEN_EN    length counter enable
//   I_TRIGGER   channel restart pulse
//   O_ON        channel active
//   O_SAMPLE    unsigned output sample (volume in the top VOL_W bits)
//   O_LFSR      debug view of the LFSR
//
// Parameter constraints: 8 <= LFSR_W <= 24, SHORT_POS < LFSR_W-1,
// OUT_W >= VOL_W, DIV_W wide enough to hold 112 << 13.
module sound_noise_channel_gen #(
  parameter int unsigned LFSR_W    = 15,
  parameter int unsigned SHORT_POS = 6,
  parameter int unsigned VOL_W     = 4,
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned OUT_W     = 20,
  parameter int unsigned DIV_W     = 24
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_CLK_EN,
  input  logic               I_TICK_256,
  input  logic               I_TICK_64,
  input  logic               I_LEN_WE,
  input  logic [LEN_W-1:0]   I_LEN,
  input  logic [VOL_W+3:0]   I_ENV,
  input  logic [7:0]         I_POLY,
  input  logic               I_LEN_EN,
  input  logic               I_TRIGGER,
  output logic               O_ON,
  output logic [OUT_W-1:0]   O_SAMPLE,
  output logic [LFSR_W-1:0]  O_LFSR
);

  localparam int unsigned LEN_CW  = LEN_W + 1;
  localparam int unsigned SHIFT_W = OUT_W - VOL_W;
  localparam logic [LEN_CW-1:0] LEN_FULL = LEN_CW'(1) << LEN_W;
  localparam logic [VOL_W-1:0]  VOL_MAX  = '1;

  logic [LEN_CW-1:0] len_cnt;
  logic [VOL_W-1:0]  vol;
  logic [2:0]        env_cnt;
  logic [DIV_W-1:0]  timer;

  // Register field decode
  logic [VOL_W-1:0] env_init;
  logic             env_up;
  logic [2:0]       env_per;
  logic             dac_on;
  logic [3:0]       div_s;
  logic             lfsr_short;
  logic [2:0]       div_r;

  assign env_init   = I_ENV[VOL_W+3:4];
  assign env_up     = I_ENV[3];
  assign env_per    = I_ENV[2:0];
  assign dac_on     = |I_ENV[VOL_W+3:3];
  assign div_s      = I_POLY[7:4];
  assign lfsr_short = I_POLY[3];
  assign div_r      = I_POLY[2:0];

  // Divisor base table
  logic [6:0] base;
  always_comb begin
    base = 7'd8;
    case (div_r)
      3'd0:    base = 7'd8;
      3'd1:    base = 7'd16;
      3'd2:    base = 7'd32;
      3'd3:    base = 7'd48;
      3'd4:    base = 7'd64;
      3'd5:    base = 7'd80;
      3'd6:    base = 7'd96;
      default: base = 7'd112;
    endcase
  end

  // Period is sampled only at reload, so field changes never disturb a running count
  logic [DIV_W-1:0] period;
  logic             timer_hold;
  logic             timer_reload;
  logic             lfsr_clk;

  assign period       = DIV_W'(base) << div_s;
  assign timer_hold   = (div_s[3:1] == 3'b111);
  assign timer_reload = I_CLK_EN && !timer_hold && (timer <= DIV_W'(1));
  assign lfsr_clk     = timer_reload && O_ON;

  // LFSR step, short mode duplicates feedback into SHORT_POS
  logic              fb;
  logic [LFSR_W-1:0] lfsr_next;
  always_comb begin
    fb        = O_LFSR[0] ^ O_LFSR[1];
    lfsr_next = {fb, O_LFSR[LFSR_W-1:1]};
    if (lfsr_short) lfsr_next[SHORT_POS] = fb;
  end

  // Length and envelope tick qualification; a trigger or length write masks ticks
  logic len_tick;
  logic len_expire;
  logic env_tick;
  logic env_wrap;
  logic env_sat;

  assign len_tick   = I_TICK_256 && I_LEN_EN && (len_cnt != '0) && !I_LEN_WE && !I_TRIGGER;
  assign len_expire = len_tick && (len_cnt == LEN_CW'(1));
  assign env_tick   = I_TICK_64 && O_ON && (env_per != 3'd0) && !I_TRIGGER;
  assign env_wrap   = env_tick && (env_cnt <= 3'd1);
  assign env_sat    = env_up ? (vol == VOL_MAX) : (vol == '0);

  // Frequency timer
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      timer <= '0;
    end else if (I_TRIGGER || timer_reload) begin
      timer <= period;
    end else if (I_CLK_EN && !timer_hold) begin
      timer <= timer - DIV_W'(1);
    end
  end

  // LFSR, clocked only while the channel is on
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      O_LFSR <= '1;
    end else if (I_TRIGGER) begin
      O_LFSR <= '1;
    end else if (lfsr_clk) begin
      O_LFSR <= lfsr_next;
    end
  end

  // Length counter; a write always wins over a tick
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      len_cnt <= '0;
    end else if (I_LEN_WE) begin
      len_cnt <= LEN_FULL - LEN_CW'(I_LEN);
    end else if (I_TRIGGER) begin
      if (len_cnt == '0) len_cnt <= LEN_FULL;
    end else if (len_tick) begin
      len_cnt <= len_cnt - LEN_CW'(1);
    end
  end

  // Volume envelope
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      vol     <= '0;
      env_cnt <= '0;
    end else if (I_TRIGGER) begin
      vol     <= env_init;
      env_cnt <= env_per;
    end else if (env_wrap) begin
      env_cnt <= env_per;
      if (!env_sat) vol <= env_up ? vol + VOL_W'(1) : vol - VOL_W'(1);
    end else if (env_tick) begin
      env_cnt <= env_cnt - 3'd1;
    end
  end

  // Channel enable: trigger sets from DAC state, DAC-off or length expiry clears
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      O_ON <= 1'b0;
    end else if (I_TRIGGER) begin
      O_ON <= dac_on;
    end else if (!dac_on || len_expire) begin
      O_ON <= 1'b0;
    end
  end

  // Output sample, one cycle behind LFSR/volume
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      O_SAMPLE <= '0;
    end else begin
      O_SAMPLE <= (O_ON && !O_LFSR[0]) ? (OUT_W'(vol) << SHIFT_W) : '0;
    end
  end

endmodule

// File: tb/tb_sound_noise_channel_gen.sv
// Directed self-checking bench for sound_noise_channel_gen (default parameters).
module tb_sound_noise_channel_gen;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_CLK_EN;
  logic        I_TICK_256;
  logic        I_TICK_64;
  logic        I_LEN_WE;
  logic [5:0]  I_LEN;
  logic [7:0]  I_ENV;
  logic [7:0]  I_POLY;
  logic        I_LEN_EN;
  logic        I_TRIGGER;
  logic        O_ON;
  logic [19:0] O_SAMPLE;
  logic [14:0] O_LFSR;

  int n_cmp = 0;
  int n_bad = 0;

  sound_noise_channel_gen dut (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .I_CLK_EN   (I_CLK_EN),
    .I_TICK_256 (I_TICK_256),
    .I_TICK_64  (I_TICK_64),
    .I_LEN_WE   (I_LEN_WE),
    .I_LEN      (I_LEN),
    .I_ENV      (I_ENV),
    .I_POLY     (I_POLY),
    .I_LEN_EN   (I_LEN_EN),
    .I_TRIGGER  (I_TRIGGER),
    .O_ON       (O_ON),
    .O_SAMPLE   (O_SAMPLE),
    .O_LFSR     (O_LFSR)
  );

  always #5 I_CLK = ~I_CLK;

  // One clock, then settle away from the edge
  task automatic cyc();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic trigger();
    I_TRIGGER = 1'b1;
    cyc();
    I_TRIGGER = 1'b0;
  endtask

  // Reference LFSR step for 15-bit register, short tap at bit 6
  function automatic logic [14:0] lfsr_ref(input logic [14:0] v, input logic short_m);
    logic       f;
    logic [14:0] n;
    f = v[0] ^ v[1];
    n = {f, v[14:1]};
    if (short_m) n[6] = f;
    return n;
  endfunction

  logic [14:0] model;
  logic [14:0] prev;
  logic [14:0] saved;
  logic        seen_hi;
  logic        seen_lo;

  initial begin
    I_RESET    = 1'b1;
    I_CLK_EN   = 1'b0;
    I_TICK_256 = 1'b0;
    I_TICK_64  = 1'b0;
    I_LEN_WE   = 1'b0;
    I_LEN      = '0;
    I_ENV      = 8'h00;
    I_POLY     = 8'h00;
    I_LEN_EN   = 1'b0;
    I_TRIGGER  = 1'b0;
    cyc();
    cyc();
    chk("rst_on", 32'(O_ON), 32'd0);
    chk("rst_sample", 32'(O_SAMPLE), 32'd0);
    chk("rst_lfsr", 32'(O_LFSR), 32'h7FFF);
    I_RESET  = 1'b0;
    I_CLK_EN = 1'b1;
    cyc();

    // Long mode, divisor 8
    I_ENV  = 8'hF0;
    I_POLY = 8'h00;
    trigger();
    chk("trig_on", 32'(O_ON), 32'd1);
    chk("trig_lfsr", 32'(O_LFSR), 32'h7FFF);
    repeat (7) cyc();
    chk("pre_first_clk", 32'(O_LFSR), 32'h7FFF);
    cyc();
    chk("first_clk", 32'(O_LFSR), 32'h3FFF);
    model   = 15'h3FFF;
    seen_hi = 1'b0;
    seen_lo = 1'b0;
    for (int k = 2; k <= 40; k++) begin
      repeat (8) cyc();
      prev  = model;
      model = lfsr_ref(model, 1'b0);
      if (k == 2) chk("second_clk", 32'(O_LFSR), 32'h1FFF);
      chk("long_lfsr", 32'(O_LFSR), 32'(model));
      chk("long_sample", 32'(O_SAMPLE), prev[0] ? 32'd0 : 32'hF0000);
      if (O_SAMPLE == 20'hF0000) seen_hi = 1'b1;
      if (O_SAMPLE == 20'h00000) seen_lo = 1'b1;
    end
    chk("sample_toggles", 32'({seen_hi, seen_lo}), 32'd3);

    // Clock enable low freezes the timer
    I_CLK_EN = 1'b0;
    repeat (40) cyc();
    chk("clk_en_hold", 32'(O_LFSR), 32'(model));
    I_CLK_EN = 1'b1;

    // DAC off without trigger, then trigger with DAC off
    I_ENV = 8'h07;
    cyc();
    chk("dac_off_live", 32'(O_ON), 32'd0);
    trigger();
    chk("dac_off_trig", 32'(O_ON), 32'd0);
    cyc();
    chk("dac_off_sample", 32'(O_SAMPLE), 32'd0);

    // Short mode: period 127 LFSR clocks
    I_ENV  = 8'hF0;
    I_POLY = 8'h08;
    trigger();
    model = 15'h7FFF;
    saved = 15'h0;
    for (int k = 1; k <= 147; k++) begin
      repeat (8) cyc();
      model = lfsr_ref(model, 1'b1);
      if (k == 20) saved = model;
      chk("short_lfsr", 32'(O_LFSR), 32'(model));
    end
    chk("short_period", 32'(O_LFSR), 32'(saved));

    // Length counter
    I_POLY   = 8'hE0;
    I_LEN    = 6'd62;
    I_LEN_WE = 1'b1;
    cyc();
    I_LEN_WE = 1'b0;
    I_LEN_EN = 1'b1;
    trigger();
    chk("len_trig_on", 32'(O_ON), 32'd1);
    I_TICK_256 = 1'b1;
    cyc();
    I_TICK_256 = 1'b0;
    chk("len_tick1", 32'(O_ON), 32'd1);
    I_TICK_256 = 1'b1;
    cyc();
    I_TICK_256 = 1'b0;
    chk("len_expire", 32'(O_ON), 32'd0);
    trigger();
    chk("len_retrig_on", 32'(O_ON), 32'd1);
    I_TICK_256 = 1'b1;
    repeat (63) cyc();
    I_TICK_256 = 1'b0;
    chk("len_63_ticks", 32'(O_ON), 32'd1);
    I_TICK_256 = 1'b1;
    cyc();
    I_TICK_256 = 1'b0;
    chk("len_64_ticks", 32'(O_ON), 32'd0);
    // Write and tick together: write wins, count stays 2
    I_LEN_WE   = 1'b1;
    I_TICK_256 = 1'b1;
    cyc();
    I_LEN_WE   = 1'b0;
    I_TICK_256 = 1'b0;
    trigger();
    I_TICK_256 = 1'b1;
    cyc();
    I_TICK_256 = 1'b0;
    chk("len_we_wins_tick1", 32'(O_ON), 32'd1);
    I_TICK_256 = 1'b1;
    cyc();
    I_TICK_256 = 1'b0;
    chk("len_we_wins_tick2", 32'(O_ON), 32'd0);
    I_LEN_EN = 1'b0;

    // s=14: LFSR frozen
    I_POLY = 8'hE0;
    trigger();
    for (int i = 0; i < 20; i++) begin
      repeat (100) cyc();
      chk("freeze_lfsr", 32'(O_LFSR), 32'h7FFF);
    end

    // Envelope up: vol 2, period 3; run LFSR to 0x4000 (out_bit=1) then freeze
    I_ENV  = 8'h2B;
    I_POLY = 8'h00;
    trigger();
    repeat (120) cyc();
    chk("env_lfsr_4000", 32'(O_LFSR), 32'h4000);
    I_POLY = 8'hE0;
    cyc();
    chk("env_init_vol", 32'(O_SAMPLE), 32'h20000);
    I_TICK_64 = 1'b1;
    repeat (3) cyc();
    I_TICK_64 = 1'b0;
    cyc();
    chk("env_step_up", 32'(O_SAMPLE), 32'h30000);
    I_TICK_64 = 1'b1;
    repeat (39) cyc();
    I_TICK_64 = 1'b0;
    cyc();
    chk("env_saturate", 32'(O_SAMPLE), 32'hF0000);
    I_TICK_64 = 1'b1;
    repeat (9) cyc();
    I_TICK_64 = 1'b0;
    cyc();
    chk("env_sat_hold", 32'(O_SAMPLE), 32'hF0000);

    // Trigger with envelope tick: tick ignored; then step down
    I_ENV     = 8'hF3;
    I_POLY    = 8'h00;
    I_TRIGGER = 1'b1;
    I_TICK_64 = 1'b1;
    cyc();
    I_TRIGGER = 1'b0;
    I_TICK_64 = 1'b0;
    repeat (120) cyc();
    chk("trig_tick_lfsr", 32'(O_LFSR), 32'h4000);
    I_POLY = 8'hE0;
    cyc();
    chk("trig_tick_vol", 32'(O_SAMPLE), 32'hF0000);
    I_TICK_64 = 1'b1;
    repeat (2) cyc();
    I_TICK_64 = 1'b0;
    cyc();
    chk("trig_tick_no_step", 32'(O_SAMPLE), 32'hF0000);
    I_TICK_64 = 1'b1;
    cyc();
    I_TICK_64 = 1'b0;
    cyc();
    chk("env_step_down", 32'(O_SAMPLE), 32'hE0000);

    // DAC off by trigger
    I_ENV = 8'h07;
    trigger();
    chk("dac07_on", 32'(O_ON), 32'd0);

    // Reset mid-run
    I_ENV  = 8'hF0;
    I_POLY = 8'h00;
    trigger();
    repeat (120) cyc();
    cyc();
    chk("prerst_sample", 32'(O_SAMPLE), 32'hF0000);
    I_RESET = 1'b1;
    #1;
    chk("midrst_on", 32'(O_ON), 32'd0);
    chk("midrst_sample", 32'(O_SAMPLE), 32'd0);
    chk("midrst_lfsr", 32'(O_LFSR), 32'h7FFF);
    repeat (3) cyc();
    I_RESET = 1'b0;
    repeat (20) cyc();
    chk("postrst_on", 32'(O_ON), 32'd0);
    chk("postrst_sample", 32'(O_SAMPLE), 32'd0);
    chk("postrst_lfsr", 32'(O_LFSR), 32'h7FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
